// File: rtl/decrementer_pkg.sv
// Shared types and helpers for the bit-serial decrementer.
package decrementer_pkg;

  // Controller states, fixed 2-bit encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width of the bit index counter for a BITS-wide operand
  function automatic int unsigned idx_width(input int unsigned bits);
    return (bits <= 2) ? 1 : $clog2(bits);
  endfunction

endpackage

// File: rtl/serial_decrementer_if.sv
// Start/busy/done handshake and operand/result bus of the serial decrementer.
interface serial_decrementer_if #(
  parameter int unsigned BITS = 16
);
  logic            start_in;
  logic [BITS-1:0] data_in;
  logic            busy_out;
  logic            done_out;
  logic [BITS-1:0] data_out;
  logic            b_out;

  // Control unit side
  modport master (
    output start_in, data_in,
    input  busy_out, done_out, data_out, b_out
  );

  // Decrementer side
  modport slave (
    input  start_in, data_in,
    output busy_out, done_out, data_out, b_out
  );
endinterface

// File: rtl/half_subtractor.sv
// Single-bit half subtractor: a - b with borrow out.
module half_subtractor (
  input  logic a_in,
  input  logic b_in,
  output logic diff_out,
  output logic b_out
);
  assign diff_out = a_in ^ b_in;
  assign b_out    = ~a_in & b_in;
endmodule

// File: rtl/serial_decrementer.sv
// Bit-serial decrement-by-one, LSB first, stopping as soon as the borrow dies.
module serial_decrementer
  import decrementer_pkg::*;
#(
  parameter int unsigned BITS = 16
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  serial_decrementer_if.slave   bus
);

  localparam int unsigned   IW       = idx_width(BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(BITS - 1);

  state_t          r_state, w_state_nxt;
  logic [BITS-1:0] r_work, w_work_nxt;
  logic [BITS-1:0] r_data_out, w_data_out_nxt;
  logic            r_borrow, w_borrow_nxt;
  logic            r_b_out, w_b_out_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic            w_bit;
  logic            w_diff;
  logic            w_borrow_out;

  assign w_bit = r_work[r_idx];

  // The one borrow cell, fed by the current work bit and the borrow flop
  half_subtractor u_hs (
    .a_in     (w_bit),
    .b_in     (r_borrow),
    .diff_out (w_diff),
    .b_out    (w_borrow_out)
  );

  // Next-state and datapath update
  always_comb begin
    w_state_nxt    = r_state;
    w_work_nxt     = r_work;
    w_borrow_nxt   = r_borrow;
    w_idx_nxt      = r_idx;
    w_data_out_nxt = r_data_out;
    w_b_out_nxt    = r_b_out;
    case (r_state)
      IDLE: begin
        if (bus.start_in) begin
          w_work_nxt   = bus.data_in;
          w_borrow_nxt = 1'b1;
          w_idx_nxt    = '0;
          w_state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        w_work_nxt[r_idx] = w_diff;
        w_borrow_nxt      = w_borrow_out;
        // Last index is forced to finish, so the index never wraps
        if (!w_borrow_out || (r_idx == LAST_IDX)) begin
          w_state_nxt    = DONE;
          w_data_out_nxt = w_work_nxt;
          w_b_out_nxt    = w_borrow_out;
        end else begin
          w_idx_nxt = IW'(r_idx + 1'b1);
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset discards any operation
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state    <= IDLE;
      r_work     <= '0;
      r_borrow   <= 1'b0;
      r_idx      <= '0;
      r_data_out <= '0;
      r_b_out    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_work     <= w_work_nxt;
      r_borrow   <= w_borrow_nxt;
      r_idx      <= w_idx_nxt;
      r_data_out <= w_data_out_nxt;
      r_b_out    <= w_b_out_nxt;
    end
  end

  assign bus.busy_out = (r_state != IDLE);
  assign bus.done_out = (r_state == DONE);
  assign bus.data_out = r_data_out;
  assign bus.b_out    = r_b_out;

endmodule

// File: tb/tb_serial_decrementer.sv
// Self-checking bench for serial_decrementer (BITS=16 main instance, BITS=4 spot check).
module tb_serial_decrementer;

  typedef struct {
    logic [15:0] data;
    logic [15:0] exp_data;
    logic        exp_b;
    int          exp_shifts;
  } vec_t;

  typedef struct {
    logic [15:0] exp_data;
    logic        exp_b;
    int          exp_shifts;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_decrementer_if #(.BITS(16)) bus16 ();
  serial_decrementer_if #(.BITS(4))  bus4 ();

  serial_decrementer #(.BITS(16)) dut (
    .clk_in   (clk),
    .reset_in (rst),
    .bus      (bus16)
  );

  serial_decrementer #(.BITS(4)) dut4 (
    .clk_in   (clk),
    .reset_in (rst),
    .bus      (bus4)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];
  int   shift_cnt = 0;
  int   busy_cnt  = 0;
  logic prev_done = 1'b0;
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference: modular subtraction plus lowest-set-bit latency
  function automatic exp_t model(input logic [15:0] d);
    exp_t e;
    bit   found;
    e.exp_data   = d - 16'd1;
    e.exp_b      = (d == 16'd0);
    e.exp_shifts = 16;
    found        = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!found && d[i]) begin
        e.exp_shifts = i + 1;
        found        = 1'b1;
      end
    end
    return e;
  endfunction

  // Scoreboard side: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (rst) begin
      shift_cnt = 0;
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (bus16.busy_out) busy_cnt++;
      if (bus16.busy_out && !bus16.done_out) shift_cnt++;
      if (bus16.done_out) begin
        check("done_single_cycle", 32'(prev_done), 32'd0);
        if (q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          mon_e = q.pop_front();
          check("data_out", 32'(bus16.data_out), 32'(mon_e.exp_data));
          check("b_out", 32'(bus16.b_out), 32'(mon_e.exp_b));
          check("shift_cycles", 32'(shift_cnt), 32'(mon_e.exp_shifts));
          check("busy_cycles", 32'(busy_cnt), 32'(mon_e.exp_shifts + 1));
        end
        shift_cnt = 0;
        busy_cnt  = 0;
      end
      prev_done = bus16.done_out;
    end
  end

  task automatic wait_not_busy();
    int k = 0;
    while (bus16.busy_out && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (bus16.busy_out) fail_now("busy_timeout");
  endtask

  task automatic start_op(input logic [15:0] d, input exp_t e);
    @(negedge clk);
    wait_not_busy();
    bus16.start_in = 1'b1;
    bus16.data_in  = d;
    @(posedge clk);
    #1;
    q.push_back(e);
    bus16.start_in = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || bus16.busy_out) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      fail_now("drain_timeout");
      q.delete();
    end
  endtask

  vec_t vecs[6];

  initial begin
    exp_t e;
    int   k;
    int   sh;
    logic seen;

    vecs[0] = '{16'h0001, 16'h0000, 1'b0, 1};
    vecs[1] = '{16'h0000, 16'hFFFF, 1'b1, 16};
    vecs[2] = '{16'h00A0, 16'h009F, 1'b0, 6};
    vecs[3] = '{16'h8000, 16'h7FFF, 1'b0, 16};
    vecs[4] = '{16'hFFFF, 16'hFFFE, 1'b0, 1};
    vecs[5] = '{16'h1234, 16'h1233, 1'b0, 3};

    rst            = 1'b1;
    bus16.start_in = 1'b0;
    bus16.data_in  = '0;
    bus4.start_in  = 1'b0;
    bus4.data_in   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(bus16.busy_out), 32'd0);
    check("rst_done", 32'(bus16.done_out), 32'd0);
    check("rst_data", 32'(bus16.data_out), 32'd0);
    check("rst_b", 32'(bus16.b_out), 32'd0);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      e.exp_data   = vecs[i].exp_data;
      e.exp_b      = vecs[i].exp_b;
      e.exp_shifts = vecs[i].exp_shifts;
      start_op(vecs[i].data, e);
      drain();
      // Result must hold in IDLE with no further pulse
      @(negedge clk);
      check("hold_data", 32'(bus16.data_out), 32'(vecs[i].exp_data));
      check("hold_done", 32'(bus16.done_out), 32'd0);
    end

    // Random operands against the model, back to back
    for (int i = 0; i < 12; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if (i == 0) d = 16'h4000;
      start_op(d, model(d));
    end
    drain();

    // Start held high while busy: only the first request runs until IDLE returns
    start_op(16'h0000, model(16'h0000));
    bus16.start_in = 1'b1;
    bus16.data_in  = 16'h1234;
    k = 0;
    @(negedge clk);
    while (bus16.busy_out && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (bus16.busy_out) fail_now("ignore_timeout");
    q.push_back(model(16'h1234));
    @(posedge clk);
    #1 bus16.start_in = 1'b0;
    drain();
    check("ignore_final", 32'(bus16.data_out), 32'h1233);

    // Reset during the 8th SHIFT cycle aborts the operation silently
    @(negedge clk);
    bus16.start_in = 1'b1;
    bus16.data_in  = 16'h0000;
    @(posedge clk);
    #1 bus16.start_in = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    check("abort_busy_before_rst", 32'(bus16.busy_out), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus16.busy_out), 32'd0);
    check("abort_data", 32'(bus16.data_out), 32'd0);
    check("abort_b", 32'(bus16.b_out), 32'd0);
    check("abort_done", 32'(bus16.done_out), 32'd0);
    repeat (25) @(negedge clk);
    start_op(16'h0002, model(16'h0002));
    drain();
    check("after_abort", 32'(bus16.data_out), 32'h0001);

    // Narrow instance: MSB-only operand runs the full width
    @(negedge clk);
    bus4.start_in = 1'b1;
    bus4.data_in  = 4'h8;
    @(posedge clk);
    #1 bus4.start_in = 1'b0;
    k    = 0;
    sh   = 0;
    seen = 1'b0;
    while (k < 50 && !seen) begin
      @(negedge clk);
      k++;
      if (bus4.done_out) seen = 1'b1;
      else if (bus4.busy_out) sh++;
    end
    check("b4_done_seen", 32'(seen), 32'd1);
    check("b4_data", 32'(bus4.data_out), 32'h7);
    check("b4_b", 32'(bus4.b_out), 32'd0);
    check("b4_shifts", 32'(sh), 32'd4);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_decrementer.md
Name: serial_decrementer

Overview:
- Multi-cycle, bit-serial decrement-by-one unit for BITS-wide words.
- Uses a single half-subtractor borrow cell, stepped LSB to MSB, one bit per clock.
- Stops early as soon as the borrow dies.
- Sits beside the register file as a low-area alternative for counter-down operations (e.g. the sequence counter and memory-word decrement paths), driven by a start/busy/done handshake from the control unit.

Parameters:
- BITS, 16, operand and result width; legal range 2 or more.

Ports:
- clk_in  input  1  sole clock; all state updates on the rising edge.
- reset_in  input  1  reset; synchronous and active-high.
- start_in  input  1  request; sampled only in IDLE.
- data_in  input  BITS  operand; captured on the edge that accepts start_in.
- busy_out  output  1  high whenever state is not IDLE.
- done_out  output  1  one-cycle pulse; result valid.
- data_out  output  BITS  result register; holds until the next accepted start.
- b_out  output  1  borrow out; 1 iff the operand was zero (wrap to all ones).

Behaviour:
- **Reset** (reset_in high at an edge, priority over everything, including mid-operation):
  - state goes to IDLE.
  - data_out, b_out, done_out and the internal bit index all go to 0.
  - Any in-flight operation is discarded with no done pulse.
- **States:** IDLE, SHIFT, DONE.
- **IDLE:**
  - If start_in=1 at an edge: work register takes data_in, borrow takes 1, index takes 0, state goes to SHIFT.
  - Otherwise hold.
  - data_out and b_out keep their previous values.
- **SHIFT** (one bit per edge, at index i):
  - Result bit i = work[i] XOR borrow.
  - New borrow = borrow AND NOT work[i].
  - Bits above i stay unchanged.
  - Go to DONE on this edge if the new borrow is 0 or i = BITS-1. Otherwise i increments.
- **Entering DONE:**
  - The same edge copies the fully-updated work word to data_out and the final borrow to b_out.
- **DONE:**
  - done_out=1 for exactly this one cycle.
  - Next edge goes to IDLE unconditionally.
- **start_in handling:**
  - start_in is ignored in SHIFT and DONE.
  - No queueing; the requester must wait for busy_out=0.
- **Latency:**
  - Start accepted at edge E. With t = index of the lowest set bit of data_in, state reaches DONE after edge E+t+1.
  - For data_in=0, state reaches DONE after edge E+BITS, with b_out=1 and data_out all ones.
  - Throughput: one operation per t+3 cycles at best.
- **Arithmetic:** result equals data_in - 1 modulo 2^BITS.
  - b_out is the borrow out of the MSB.
  - No other flags.
- **busy_out and done_out:**
  - busy_out is combinational from state; it is high in SHIFT and DONE.
  - done_out is combinational from state (state = DONE).
- **Index counter:**
  - Width is clog2(BITS).
  - It never wraps, because the transition at BITS-1 is forced.

Decomposition:
- Shared package (decrementer_pkg):
  - State enum typedef (IDLE/SHIFT/DONE), explicitly 2-bit encoded.
  - A localparam function for index width.
- One sub-module, half_subtractor:
  - Outputs: diff_out = a XOR b, b_out = NOT a AND b.
  - Inputs: a_in, b_in.
  - Instantiated once inside the SHIFT datapath, with b_in driven by the borrow flop.

Test Plan:
- **BITS=16, data_in=0x0001, start pulse:**
  - Exactly 1 SHIFT cycle.
  - done_out one cycle, data_out=0x0000, b_out=0.
  - busy_out high for 2 cycles.
- **data_in=0x0000:**
  - 16 SHIFT cycles.
  - data_out=0xFFFF, b_out=1, single done pulse.
- **data_in=0x00A0:**
  - 6 SHIFT cycles (early termination at bit 5).
  - data_out=0x009F, b_out=0.
- **data_in=0x8000:**
  - 16 SHIFT cycles.
  - data_out=0x7FFF, b_out=0.
  - Separately, with BITS=4, data_in=0x8 gives 0x7.
- **Start with 0x0000; re-assert start_in with 0x1234 every cycle while busy:**
  - Only the first request runs; result 0xFFFF.
  - The next start is accepted only after the return to IDLE, giving 0x1233.
- **Start with 0x0000; assert reset_in during the 8th SHIFT cycle:**
  - Next cycle: busy_out=0, data_out=0, b_out=0.
  - No done pulse ever appears for the aborted operation.
  - A following start with 0x0002 yields 0x0001.
